// File: rtl/zero_mask_gen.sv
// zero_mask_gen: emits N WIDTH-bit mask words that together hold exactly
// min(Z, N*WIDTH) zero bits, packed LSB-first across the stream with all
// remaining bits set to one. Used to build lane-disable and tail masks.
module zero_mask_gen #(
  parameter int WIDTH    = 16,
  parameter int MAXWORDS = 8,
  parameter int CNT_W    = 8,
  parameter int NW_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_cnt_in,
  input  logic [NW_W-1:0]  i_words_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_err
);

  // rem needs one bit beyond CNT_W; the product is formed wide enough that
  // N*WIDTH can never truncate, even for an out-of-range N.
  localparam int REM_W = CNT_W + 1;
  localparam int PW    = CNT_W + NW_W + $clog2(WIDTH + 1) + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           r_state, w_stateNext;
  logic [REM_W-1:0] r_rem, w_remNext;
  logic [NW_W-1:0]  r_left, w_leftNext;
  logic [WIDTH-1:0] r_data, w_dataNext;
  logic             r_valid, w_validNext;
  logic             r_last, w_lastNext;
  logic             r_err, w_errNext;

  logic [PW-1:0]    w_total;
  logic [PW-1:0]    w_reqCnt;
  logic             w_badN;
  logic             w_clamp;
  logic [REM_W-1:0] w_startRem;
  logic [REM_W-1:0] w_zw;
  logic [REM_W-1:0] w_remAfter;
  logic [NW_W-1:0]  w_leftAfter;

  // Thermometer word: bit i is zero while fewer than rem zeros precede it.
  function automatic logic [WIDTH-1:0] maskFor(input logic [REM_W-1:0] rem);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (REM_W'(i) < rem) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

  assign w_total     = PW'(i_words_in) * PW'(WIDTH);
  assign w_reqCnt    = PW'(i_cnt_in);
  assign w_badN      = (i_words_in == '0) || (i_words_in > NW_W'(MAXWORDS));
  assign w_clamp     = (w_reqCnt > w_total);
  assign w_startRem  = w_clamp ? REM_W'(w_total) : REM_W'(i_cnt_in);
  assign w_zw        = (r_rem > REM_W'(WIDTH)) ? REM_W'(WIDTH) : r_rem;
  assign w_remAfter  = r_rem - w_zw;
  assign w_leftAfter = r_left - NW_W'(1);

  // Next-state and next-datapath decisions for the accept/emit sequencing.
  always_comb begin
    w_stateNext = r_state;
    w_remNext   = r_rem;
    w_leftNext  = r_left;
    w_dataNext  = r_data;
    w_validNext = r_valid;
    w_lastNext  = r_last;
    w_errNext   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          if (w_badN) begin
            w_errNext = 1'b1;
          end else begin
            w_stateNext = EMIT;
            w_remNext   = w_startRem;
            w_leftNext  = i_words_in;
            w_dataNext  = maskFor(w_startRem);
            w_lastNext  = (i_words_in == NW_W'(1));
            w_validNext = 1'b1;
            w_errNext   = w_clamp;
          end
        end
      end
      EMIT: begin
        if (r_valid && i_out_ready) begin
          if (r_last) begin
            w_stateNext = IDLE;
            w_remNext   = '0;
            w_leftNext  = '0;
            w_dataNext  = '1;
            w_lastNext  = 1'b0;
            w_validNext = 1'b0;
          end else begin
            w_remNext   = w_remAfter;
            w_leftNext  = w_leftAfter;
            w_dataNext  = maskFor(w_remAfter);
            w_lastNext  = (w_leftAfter == NW_W'(1));
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers: remaining zeros, words left, current word and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_left  <= '0;
      r_data  <= '1;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rem   <= w_remNext;
      r_left  <= w_leftNext;
      r_data  <= w_dataNext;
      r_valid <= w_validNext;
      r_last  <= w_lastNext;
      r_err   <= w_errNext;
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_busy      = (r_state == EMIT);
  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_out_last  = r_last;
  assign o_err       = r_err;

endmodule
